// File: rtl/fsm_gen_pkg.sv
// Shared types and defaults for the table-driven FSM engine.
package fsm_gen_pkg;

  localparam int DEF_NSTATES = 6;
  localparam int DEF_SW      = 3;
  localparam int DEF_WORD_W  = 8;

  typedef logic [DEF_SW-1:0] state_t;

  localparam state_t ST_A = 3'd0;
  localparam state_t ST_B = 3'd1;
  localparam state_t ST_C = 3'd2;
  localparam state_t ST_D = 3'd3;
  localparam state_t ST_E = 3'd4;
  localparam state_t ST_F = 3'd5;

  typedef enum logic [1:0] {IDLE, RUN, DONE} ctl_t;

endpackage

// File: rtl/fsm_table_regs.sv
// Next-state / output table: NSTATES x 2 entries of {next,y}.
// It has one write port and a combinational read on (state, input bit).
module fsm_table_regs #(
  parameter int NSTATES = 6,
  parameter int SW      = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [SW-1:0] wr_state,
  input  logic          wr_x,
  input  logic [SW-1:0] wr_next,
  input  logic          wr_y,
  input  logic [SW-1:0] rd_state,
  input  logic          rd_x,
  output logic [SW-1:0] rd_next,
  output logic          rd_y
);
  localparam logic [SW-1:0] LAST_ST = SW'(NSTATES-1);

  logic [SW-1:0] nxt_q [NSTATES][2];
  logic          y_q   [NSTATES][2];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < NSTATES; s++) begin
        for (int x = 0; x < 2; x++) begin
          nxt_q[s][x] <= '0;
          y_q[s][x]   <= 1'b0;
        end
      end
    end else if (we) begin
      for (int s = 0; s < NSTATES; s++) begin
        for (int x = 0; x < 2; x++) begin
          if (wr_state == SW'(s) && wr_x == x[0]) begin
            nxt_q[s][x] <= wr_next;
            y_q[s][x]   <= wr_y;
          end
        end
      end
    end
  end

  // An out-of-range row reads as {A,0}, which keeps the engine inside the legal states.
  always_comb begin
    rd_next = '0;
    rd_y    = 1'b0;
    if (rd_state <= LAST_ST) begin
      rd_next = nxt_q[rd_state][rd_x];
      rd_y    = y_q[rd_state][rd_x];
    end
  end

endmodule

// File: rtl/fsm_table_runner.sv
// Table-driven Mealy FSM engine: it takes words in, applies them LSB-first as x and packs y into a result word.
// Define FSM_RESTART_EN to return to state A on every accepted word.
module fsm_table_runner
  import fsm_gen_pkg::*;
#(
  parameter int NSTATES = DEF_NSTATES,
  parameter int SW      = DEF_SW,
  parameter int WORD_W  = DEF_WORD_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_we,
  input  logic [SW-1:0]     cfg_state,
  input  logic              cfg_x,
  input  logic [SW-1:0]     cfg_next,
  input  logic              cfg_y,
  output logic              cfg_err,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  output logic              busy,
  output logic [SW-1:0]     cur_state
);
  localparam int            CW       = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [SW-1:0] LAST_ST  = SW'(NSTATES-1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WORD_W-1);

  ctl_t              ctl;
  logic [WORD_W-1:0] word_q, res_q;
  logic [CW-1:0]     bit_cnt;
  logic [SW-1:0]     state_q;

  logic              pend_vld, pend_x, pend_y;
  logic [SW-1:0]     pend_state, pend_next;

  logic              accept, cfg_ok, cur_bit;
  logic              tbl_we, tbl_x, tbl_y, rd_y;
  logic [SW-1:0]     tbl_state, tbl_next, rd_next;

  assign in_ready  = (ctl == IDLE);
  assign out_valid = (ctl == DONE);
  assign busy      = (ctl != IDLE);
  assign out_data  = res_q;
  assign cur_state = state_q;

  assign accept  = in_valid && in_ready;
  assign cfg_ok  = cfg_we && (ctl == IDLE) && (cfg_state <= LAST_ST) && (cfg_next <= LAST_ST);
  assign cur_bit = word_q[bit_cnt];

  // A write that lands together with a word accept is delayed one cycle, so bit 0 still sees the old table.
  assign tbl_we    = pend_vld || (cfg_ok && !accept);
  assign tbl_state = pend_vld ? pend_state : cfg_state;
  assign tbl_x     = pend_vld ? pend_x     : cfg_x;
  assign tbl_next  = pend_vld ? pend_next  : cfg_next;
  assign tbl_y     = pend_vld ? pend_y     : cfg_y;

  fsm_table_regs #(.NSTATES(NSTATES), .SW(SW)) u_tbl (
    .clk      (clk),
    .reset    (reset),
    .we       (tbl_we),
    .wr_state (tbl_state),
    .wr_x     (tbl_x),
    .wr_next  (tbl_next),
    .wr_y     (tbl_y),
    .rd_state (state_q),
    .rd_x     (cur_bit),
    .rd_next  (rd_next),
    .rd_y     (rd_y)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_vld   <= 1'b0;
      pend_state <= '0;
      pend_x     <= 1'b0;
      pend_next  <= '0;
      pend_y     <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      pend_vld <= cfg_ok && accept;
      if (cfg_ok && accept) begin
        pend_state <= cfg_state;
        pend_x     <= cfg_x;
        pend_next  <= cfg_next;
        pend_y     <= cfg_y;
      end
      if (cfg_we && !cfg_ok) cfg_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctl     <= IDLE;
      word_q  <= '0;
      res_q   <= '0;
      bit_cnt <= '0;
    end else begin
      case (ctl)
        IDLE: if (accept) begin
          word_q  <= in_data;
          bit_cnt <= '0;
          ctl     <= RUN;
        end
        RUN: begin
          res_q[bit_cnt] <= rd_y;
          bit_cnt        <= bit_cnt + 1'b1;
          if (bit_cnt == LAST_BIT) ctl <= DONE;
        end
        DONE: if (out_ready) ctl <= IDLE;
        default: ctl <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= SW'(ST_A);
    end else if (state_q > LAST_ST) begin
      state_q <= '0;
    end else if (ctl == RUN) begin
      state_q <= rd_next;
`ifdef FSM_RESTART_EN
    end else if (accept) begin
      state_q <= SW'(ST_A);
`endif
    end
  end

endmodule

// File: tb/tb_fsm_table_runner.sv
// Randomized bench for fsm_table_runner with a behavioural table/state reference model.
module tb_fsm_table_runner;
  import fsm_gen_pkg::*;

  localparam int NS = 6;
  localparam int W  = 8;

  logic         clk = 1'b0, reset = 1'b0;
  logic         cfg_we = 1'b0, cfg_x = 1'b0, cfg_y = 1'b0;
  logic [2:0]   cfg_state = '0, cfg_next = '0;
  logic         cfg_err;
  logic         in_valid = 1'b0, in_ready;
  logic [W-1:0] in_data = '0;
  logic         out_valid, out_ready = 1'b0;
  logic [W-1:0] out_data;
  logic         busy;
  logic [2:0]   cur_state;

  fsm_table_runner dut (
    .clk(clk), .reset(reset),
    .cfg_we(cfg_we), .cfg_state(cfg_state), .cfg_x(cfg_x), .cfg_next(cfg_next), .cfg_y(cfg_y),
    .cfg_err(cfg_err),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .cur_state(cur_state)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int m_nxt [NS][2];
  int m_y   [NS][2];
  int m_st, m_err;
  int tn [12];
  int ty [12];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model;
    for (int s = 0; s < NS; s++) for (int x = 0; x < 2; x++) begin
      m_nxt[s][x] = 0;
      m_y[s][x]   = 0;
    end
    m_st  = 0;
    m_err = 0;
  endtask

  function automatic void model_write(input int s, input int x, input int n, input int y);
    if (s < NS && n < NS) begin
      m_nxt[s][x] = n;
      m_y[s][x]   = y;
    end else m_err = 1;
  endfunction

  // Writes issued while the engine is idle
  task automatic cfg_write(input int s, input int x, input int n, input int y);
    cfg_we = 1'b1; cfg_state = s[2:0]; cfg_x = x[0]; cfg_next = n[2:0]; cfg_y = y[0];
    model_write(s, x, n, y);
    tick;
    cfg_we = 1'b0;
    chk("cfg_err", cfg_err, m_err);
  endtask

  task automatic run_word(input logic [W-1:0] d, input int hold, input bit mid_cfg,
                          input bit coll, input int cs, input int cx, input int cn, input int cy,
                          output logic [W-1:0] res);
    logic [W-1:0] exp, first;
    int n, b;
`ifdef FSM_RESTART_EN
    m_st = 0;
`endif
    for (int i = 0; i < W; i++) begin
      b      = int'(d[i]);
      exp[i] = (m_y[m_st][b] != 0);
      m_st   = m_nxt[m_st][b];
      if (coll && i == 0) model_write(cs, cx, cn, cy);
    end
    if (mid_cfg) m_err = 1;

    chk("in_ready_idle", in_ready, 1);
    in_valid = 1'b1; in_data = d;
    if (coll) begin
      cfg_we = 1'b1; cfg_state = cs[2:0]; cfg_x = cx[0]; cfg_next = cn[2:0]; cfg_y = cy[0];
    end
    tick;
    in_valid = 1'b0; cfg_we = 1'b0; in_data = W'($urandom);
    chk("busy_run", busy, 1);

    n = 0;
    while (!out_valid && n < 20) begin
      if (mid_cfg && n == 2) begin
        cfg_we = 1'b1; cfg_state = 3'd0; cfg_x = 1'b0; cfg_next = 3'd3; cfg_y = 1'b1;
      end
      tick;
      cfg_we = 1'b0;
      n++;
    end
    // Valid rises after one edge per input bit following the accept edge
    chk("latency", n, W);

    first = out_data;
    for (int h = 0; h < hold; h++) begin
      tick;
      chk("hold_valid", out_valid, 1);
      chk("hold_data", out_data, first);
      chk("hold_in_ready", in_ready, 0);
    end
    chk("out_data", out_data, exp);
    chk("cur_state", cur_state, m_st);
    chk("cfg_err_word", cfg_err, m_err);
    res = out_data;

    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    chk("valid_drop", out_valid, 0);
    chk("ready_back", in_ready, 1);
  endtask

  initial begin
    logic [W-1:0] res, d;
    int s0, b0;

    tn = '{4, 3, 5, 3, 4, 1, 5, 1, 2, 5, 1, 2};
    ty = '{0, 1, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0};
    clear_model;

    repeat (3) tick;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cfg_err", cfg_err, 0);
    chk("rst_state", cur_state, 0);
    reset = 1'b1;
    tick;

    for (int s = 0; s < NS; s++) for (int x = 0; x < 2; x++) cfg_write(s, x, tn[2*s+x], ty[2*s+x]);

    run_word(8'hFF, 0, 0, 0, 0, 0, 0, 0, res);
    chk("t1_const", res, 8'h01);
    chk("t1_state", cur_state, ST_B);

    run_word(8'h02, 0, 0, 0, 0, 0, 0, 0, res);
`ifdef FSM_RESTART_EN
    chk("t2_const", res, 8'h02);
    chk("t2_state", cur_state, ST_F);
`endif

    run_word(W'($urandom), 5, 0, 0, 0, 0, 0, 0, res);

    run_word(W'($urandom), 0, 1, 0, 0, 0, 0, 0, res);
    cfg_write(0, 0, 6, 1);
    cfg_write(7, 1, 2, 0);

    // A write that collides with an accept targets the entry used by bit 0
    d = W'($urandom);
`ifdef FSM_RESTART_EN
    s0 = 0;
`else
    s0 = m_st;
`endif
    b0 = int'(d[0]);
    run_word(d, 0, 0, 1, s0, b0, (m_nxt[s0][b0] + 1) % NS, 1 - m_y[s0][b0], res);

    run_word(8'h01, 0, 0, 0, 0, 0, 0, 0, res);
    run_word(8'h00, 0, 0, 0, 0, 0, 0, 0, res);

    for (int k = 0; k < 24; k++)
      run_word(W'($urandom), int'($urandom_range(0, 3)), 0, 0, 0, 0, 0, 0, res);

    in_valid = 1'b1; in_data = W'($urandom);
    tick;
    in_valid = 1'b0;
    repeat (3) tick;
    reset = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_state", cur_state, 0);
    chk("mid_rst_ready", in_ready, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_err", cfg_err, 0);
    tick;
    reset = 1'b1;
    clear_model;
    tick;
    run_word(8'h00, 0, 0, 0, 0, 0, 0, 0, res);
    chk("zero_tbl_const", res, 8'h00);
    run_word(W'($urandom), 1, 0, 0, 0, 0, 0, 0, res);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
